// File: rtl/dla_noc_packetizer_pkg.sv
// Shared types and sizes for the DLA NoC injection packetizer.
package dla_noc_packetizer_pkg;

  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int DEST_ADDR_SIZE_L = 2;
  // Grant payload is {x, y, dla[1:0]}
  localparam int GRANT_PL_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + 2;
  // Grant field sits directly above the destination fields in a head payload
  localparam int HEAD_GRANT_OFS   = DEST_ADDR_SIZE_L + DEST_ADDR_SIZE_Y + DEST_ADDR_SIZE_X;

  localparam int FLIT_LABEL_SIZE  = 2;
  localparam int FLIT_DATA_SIZE   = 32;
  localparam int FLIT_TOTAL_SIZE  = FLIT_LABEL_SIZE + FLIT_DATA_SIZE;

  typedef enum logic [FLIT_LABEL_SIZE-1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HT   = 2'd1,
    HD   = 2'd2,
    BD   = 2'd3
  } pkt_state_t;

endpackage

// File: rtl/dla_noc_packetizer_if.sv
// Request / data / injection-FIFO bundle of the DLA NoC packetizer.
// slave = packetizer side, master = DLA source plus FIFO side.
interface dla_noc_packetizer_if #(
  parameter int LEN_W = $clog2(256 + 1)
);
  import dla_noc_packetizer_pkg::*;

  logic                        req_vld;
  logic                        req_rdy;
  logic [DEST_ADDR_SIZE_X-1:0] req_dest_x;
  logic [DEST_ADDR_SIZE_Y-1:0] req_dest_y;
  logic [DEST_ADDR_SIZE_L-1:0] req_dest_l;
  logic [LEN_W-1:0]            req_len;
  logic [GRANT_PL_SIZE-1:0]    req_grant_pl;
  logic                        dat_vld;
  logic                        dat_rdy;
  logic [FLIT_DATA_SIZE-1:0]   dat_data;
  logic                        noc_wrbuf_full;
  logic                        noc_wrbuf_wen;
  logic [FLIT_TOTAL_SIZE-1:0]  noc_wrbuf_wdata;
  logic                        busy;
  logic [31:0]                 pkt_cnt;
  logic [31:0]                 flit_cnt;

  modport slave (
    input  req_vld, req_dest_x, req_dest_y, req_dest_l, req_len, req_grant_pl,
    input  dat_vld, dat_data, noc_wrbuf_full,
    output req_rdy, dat_rdy, noc_wrbuf_wen, noc_wrbuf_wdata, busy, pkt_cnt, flit_cnt
  );

  modport master (
    output req_vld, req_dest_x, req_dest_y, req_dest_l, req_len, req_grant_pl,
    output dat_vld, dat_data, noc_wrbuf_full,
    input  req_rdy, dat_rdy, noc_wrbuf_wen, noc_wrbuf_wdata, busy, pkt_cnt, flit_cnt
  );

endinterface

// File: rtl/dla_noc_packetizer.sv
// DLA NoC packetizer: turns one request (dest + beat count) plus a beat
// stream into labelled flits for the injection FIFO write port.
// Optional packet/flit counters are built only with DLA_PKT_STATS_EN.
module dla_noc_packetizer
  import dla_noc_packetizer_pkg::*;
#(
  parameter int MAX_BEATS = 256,
  parameter int LEN_W     = $clog2(MAX_BEATS + 1)
) (
  input logic                 clk_dla,
  input logic                 rst_dla,
  dla_noc_packetizer_if.slave bus
);

  pkt_state_t                  state_q, state_d;
  logic [DEST_ADDR_SIZE_X-1:0] dest_x_q, dest_x_d;
  logic [DEST_ADDR_SIZE_Y-1:0] dest_y_q, dest_y_d;
  logic [DEST_ADDR_SIZE_L-1:0] dest_l_q, dest_l_d;
  logic [GRANT_PL_SIZE-1:0]    grant_q, grant_d;
  logic [LEN_W-1:0]            remaining_q, remaining_d;

  logic [LEN_W-1:0]            len_clamped;
  logic [FLIT_DATA_SIZE-1:0]   head_pl;
  logic [FLIT_DATA_SIZE-1:0]   grant_pl;
  flit_label_t                 body_lbl;
  logic                        req_rdy, dat_rdy, wen;
  logic [FLIT_TOTAL_SIZE-1:0]  wdata;

  // Oversized requests are cut to MAX_BEATS; the source drops the leftovers.
  assign len_clamped = (bus.req_len > LEN_W'(MAX_BEATS)) ? LEN_W'(MAX_BEATS) : bus.req_len;

  // Head payload fields; only HEADTAIL flits carry the grant field.
  always_comb begin
    head_pl                                       = '0;
    head_pl[0 +: DEST_ADDR_SIZE_L]                = dest_l_q;
    head_pl[DEST_ADDR_SIZE_L +: DEST_ADDR_SIZE_Y] = dest_y_q;
    head_pl[DEST_ADDR_SIZE_L + DEST_ADDR_SIZE_Y +: DEST_ADDR_SIZE_X] = dest_x_q;
    grant_pl                                      = '0;
    grant_pl[HEAD_GRANT_OFS +: GRANT_PL_SIZE]     = grant_q;
    body_lbl = (remaining_q == LEN_W'(1)) ? TAIL : BODY;
  end

  // Next state, handshakes and the combinational FIFO write port.
  always_comb begin
    state_d     = state_q;
    dest_x_d    = dest_x_q;
    dest_y_d    = dest_y_q;
    dest_l_d    = dest_l_q;
    grant_d     = grant_q;
    remaining_d = remaining_q;
    req_rdy     = 1'b0;
    dat_rdy     = 1'b0;
    wen         = 1'b0;
    wdata       = '0;
    case (state_q)
      IDLE: begin
        req_rdy = 1'b1;
        if (bus.req_vld) begin
          dest_x_d    = bus.req_dest_x;
          dest_y_d    = bus.req_dest_y;
          dest_l_d    = bus.req_dest_l;
          grant_d     = bus.req_grant_pl;
          remaining_d = len_clamped;
          state_d     = (len_clamped == '0) ? HT : HD;
        end
      end
      HT: begin
        if (!bus.noc_wrbuf_full) begin
          wen     = 1'b1;
          wdata   = {HEADTAIL, head_pl | grant_pl};
          state_d = IDLE;
        end
      end
      HD: begin
        if (!bus.noc_wrbuf_full) begin
          wen     = 1'b1;
          wdata   = {HEAD, head_pl};
          state_d = BD;
        end
      end
      BD: begin
        dat_rdy = !bus.noc_wrbuf_full;
        if (bus.dat_vld && !bus.noc_wrbuf_full) begin
          wen         = 1'b1;
          wdata       = {body_lbl, bus.dat_data};
          remaining_d = remaining_q - LEN_W'(1);
          if (body_lbl == TAIL) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and packet context registers.
  always_ff @(posedge clk_dla or posedge rst_dla) begin
    if (rst_dla) begin
      state_q     <= IDLE;
      dest_x_q    <= '0;
      dest_y_q    <= '0;
      dest_l_q    <= '0;
      grant_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      dest_x_q    <= dest_x_d;
      dest_y_q    <= dest_y_d;
      dest_l_q    <= dest_l_d;
      grant_q     <= grant_d;
      remaining_q <= remaining_d;
    end
  end

  assign bus.req_rdy         = req_rdy;
  assign bus.dat_rdy         = dat_rdy;
  assign bus.noc_wrbuf_wen   = wen;
  assign bus.noc_wrbuf_wdata = wdata;
  assign bus.busy            = (state_q != IDLE);

`ifdef DLA_PKT_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d, flit_cnt_q, flit_cnt_d;
  logic        pkt_end;

  // A packet ends on a HEADTAIL write or a TAIL write.
  assign pkt_end = wen && ((state_q == HT) || (body_lbl == TAIL && state_q == BD));

  // Free-running counters, wrap modulo 2^32.
  always_comb begin
    flit_cnt_d = flit_cnt_q + (wen ? 32'd1 : 32'd0);
    pkt_cnt_d  = pkt_cnt_q + (pkt_end ? 32'd1 : 32'd0);
  end

  // Counter registers.
  always_ff @(posedge clk_dla or posedge rst_dla) begin
    if (rst_dla) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end

  assign bus.pkt_cnt  = pkt_cnt_q;
  assign bus.flit_cnt = flit_cnt_q;
`else
  assign bus.pkt_cnt  = '0;
  assign bus.flit_cnt = '0;
`endif

endmodule

// File: tb/tb_dla_noc_packetizer.sv
// Directed bench for dla_noc_packetizer: a queue model of the flit stream
// checked every cycle, plus literal flit values for each directed case.
module tb_dla_noc_packetizer;
  import dla_noc_packetizer_pkg::*;

  localparam int MAXB = 256;
  localparam int LENW = $clog2(MAXB + 1);
  localparam int XW   = DEST_ADDR_SIZE_X;
  localparam int YW   = DEST_ADDR_SIZE_Y;
  localparam int LW   = DEST_ADDR_SIZE_L;
`ifdef DLA_PKT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [FLIT_TOTAL_SIZE-1:0] flit_t;

  logic        clk_dla = 1'b0;
  logic        rst_dla = 1'b1;
  int          total = 0, bad = 0, cyc = 0, m_pkts = 0, m_flits = 0;
  bit          chk_en = 1'b0;
  flit_t       exp_q[$];
  flit_t       log_f[$];
  int          log_c[$];
  logic [31:0] src_q[$];
  int          gap_q[$];

  always #5 clk_dla = ~clk_dla;
  always @(posedge clk_dla) cyc <= cyc + 1;

  dla_noc_packetizer_if #(.LEN_W(LENW)) bus ();

  dla_noc_packetizer #(.MAX_BEATS(MAXB)) dut (
    .clk_dla (clk_dla),
    .rst_dla (rst_dla),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model flit builders: plain arithmetic on the field layout.
  function automatic flit_t mk_head(input int x, input int y, input int l, input int g, input bit ht);
    int          p;
    logic [31:0] pw;
    p  = l + y * (1 << LW) + x * (1 << (LW + YW)) + (ht ? g * (1 << (LW + YW + XW)) : 0);
    pw = p;
    return {ht ? 2'd3 : 2'd0, pw};
  endfunction

  function automatic flit_t mk_data(input logic [31:0] d, input bit last);
    return {last ? 2'd2 : 2'd1, d};
  endfunction

  // Per-cycle compare against the model queue.
  always @(negedge clk_dla) begin
    flit_t e;
    if (chk_en && !rst_dla) begin
      check("pkt_cnt", 64'(bus.pkt_cnt), 64'(STATS ? m_pkts : 0));
      check("flit_cnt", 64'(bus.flit_cnt), 64'(STATS ? m_flits : 0));
      check("req_rdy_vs_busy", 64'(bus.req_rdy), 64'(!bus.busy));
      if (bus.noc_wrbuf_full)
        check("stall_on_full", 64'({bus.noc_wrbuf_wen, bus.dat_rdy}), 64'(0));
      if (bus.dat_vld && bus.dat_rdy)
        check("beat_writes", 64'(bus.noc_wrbuf_wen), 64'(1));
      if (bus.noc_wrbuf_wen) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got %0h want none", bus.noc_wrbuf_wdata);
        end else begin
          e = exp_q.pop_front();
          check("flit", 64'(bus.noc_wrbuf_wdata), 64'(e));
          m_flits++;
          if (e[FLIT_TOTAL_SIZE-1]) m_pkts++;
        end
        log_f.push_back(bus.noc_wrbuf_wdata);
        log_c.push_back(cyc);
      end
    end
  end

  // Beat source: holds each beat until consumed, optional idle gap before it.
  initial begin
    bit hs;
    bus.dat_vld  = 1'b0;
    bus.dat_data = '0;
    forever begin
      @(negedge clk_dla);
      hs = bus.dat_vld && bus.dat_rdy && !rst_dla;
      @(posedge clk_dla);
      #1;
      if (hs && src_q.size() > 0) begin
        void'(src_q.pop_front());
        void'(gap_q.pop_front());
      end
      if (src_q.size() > 0 && gap_q[0] == 0) begin
        bus.dat_vld  = 1'b1;
        bus.dat_data = src_q[0];
      end else begin
        if (src_q.size() > 0) gap_q[0] = gap_q[0] - 1;
        bus.dat_vld = 1'b0;
      end
    end
  end

  task automatic send_req(input int x, input int y, input int l, input int len, input int g,
                          input logic [31:0] base, input int gap, output int acc);
    int n;
    for (int i = 0; i < len; i++) begin
      src_q.push_back(base + i);
      gap_q.push_back(i == 0 ? 0 : gap);
    end
    @(posedge clk_dla);
    #1;
    bus.req_vld      = 1'b1;
    bus.req_dest_x   = XW'(x);
    bus.req_dest_y   = YW'(y);
    bus.req_dest_l   = LW'(l);
    bus.req_len      = LENW'(len);
    bus.req_grant_pl = GRANT_PL_SIZE'(g);
    acc = -1;
    for (int k = 0; k < 2000 && acc < 0; k++) begin
      @(negedge clk_dla);
      if (bus.req_rdy) acc = cyc;
      @(posedge clk_dla);
      #1;
    end
    bus.req_vld = 1'b0;
    if (acc < 0) begin
      total++;
      bad++;
      $display("FAIL req_accept_timeout: got no accept want accept");
    end else begin
      n = (len > MAXB) ? MAXB : len;
      exp_q.push_back(mk_head(x, y, l, g, n == 0));
      for (int i = 0; i < n; i++) exp_q.push_back(mk_data(base + i, i == n - 1));
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk_dla);
      #1;
      done = (exp_q.size() == 0) && !bus.busy;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy want idle", name);
    end
  endtask

  task automatic wait_log(input int target);
    bit done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk_dla);
      #1;
      done = (log_f.size() >= target);
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL write_wait_timeout: got %0d want %0d", log_f.size(), target);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, acc, acc2, h;
    bus.req_vld        = 1'b0;
    bus.req_dest_x     = '0;
    bus.req_dest_y     = '0;
    bus.req_dest_l     = '0;
    bus.req_len        = '0;
    bus.req_grant_pl   = '0;
    bus.noc_wrbuf_full = 1'b0;

    // Reset values
    #12;
    check("rst_req_rdy", 64'(bus.req_rdy), 64'(1));
    check("rst_dat_rdy", 64'(bus.dat_rdy), 64'(0));
    check("rst_wen", 64'(bus.noc_wrbuf_wen), 64'(0));
    check("rst_wdata", 64'(bus.noc_wrbuf_wdata), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_pkt_cnt", 64'(bus.pkt_cnt), 64'(0));
    #10 rst_dla = 1'b0;
    chk_en = 1'b1;

    // Grant packet: x=3 y=5 l=1, grant {2,1,2'b10}=0x86
    s = log_f.size();
    send_req(3, 5, 1, 0, 134, 32'h0, 0, acc);
    wait_idle("grant");
    check("grant_count", 64'(log_f.size() - s), 64'(1));
    check("grant_flit", 64'(log_f[s]), 64'(34'h3000218D5));
    check("grant_latency", 64'(log_c[s]), 64'(acc + 1));
    check("grant_pkt_cnt", 64'(bus.pkt_cnt), 64'(STATS ? 1 : 0));

    // Three beats back-to-back; grant input must not leak into HEAD
    s = log_f.size();
    send_req(1, 2, 3, 3, 1023, 32'hA0, 0, acc);
    wait_idle("three");
    check("three_count", 64'(log_f.size() - s), 64'(4));
    check("three_head", 64'(log_f[s]), 64'(34'h00000004B));
    check("three_body_a", 64'(log_f[s+1]), 64'(34'h1000000A0));
    check("three_body_b", 64'(log_f[s+2]), 64'(34'h1000000A1));
    check("three_tail_c", 64'(log_f[s+3]), 64'(34'h2000000A2));
    for (int i = 0; i < 4; i++) check("three_cycle", 64'(log_c[s+i]), 64'(acc + 1 + i));
    check("three_flit_cnt", 64'(bus.flit_cnt), 64'(STATS ? 5 : 0));

    // Single beat: HEAD then TAIL
    s = log_f.size();
    send_req(2, 1, 0, 1, 0, 32'hD0, 0, acc);
    wait_idle("single");
    check("single_count", 64'(log_f.size() - s), 64'(2));
    check("single_head", 64'(log_f[s]), 64'(34'h000000084));
    check("single_tail", 64'(log_f[s+1]), 64'(34'h2000000D0));
    check("single_tail_cycle", 64'(log_c[s+1]), 64'(acc + 2));

    // Backpressure: 5 full cycles in HD, 2 mid-body
    s = log_f.size();
    bus.noc_wrbuf_full = 1'b1;
    send_req(1, 1, 1, 3, 0, 32'hB0, 0, acc);
    repeat (5) begin
      @(posedge clk_dla);
      #1;
    end
    bus.noc_wrbuf_full = 1'b0;
    wait_log(s + 2);
    @(posedge clk_dla);
    #1;
    bus.noc_wrbuf_full = 1'b1;
    repeat (2) begin
      @(posedge clk_dla);
      #1;
    end
    bus.noc_wrbuf_full = 1'b0;
    wait_idle("bp");
    check("bp_count", 64'(log_f.size() - s), 64'(4));
    check("bp_head", 64'(log_f[s]), 64'(34'h000000045));
    check("bp_head_cycle", 64'(log_c[s]), 64'(acc + 6));
    check("bp_tail", 64'(log_f[s+3]), 64'(34'h2000000B2));
    check("bp_tail_cycle", 64'(log_c[s+3]), 64'(acc + 11));

    // Bubbles (1010) with a second request raised during body
    s = log_f.size();
    send_req(1, 1, 1, 4, 0, 32'hC0, 1, acc);
    h = acc + 1;
    wait_log(s + 2);
    send_req(2, 2, 2, 2, 0, 32'hE0, 0, acc2);
    wait_idle("overlap");
    check("ovl_count", 64'(log_f.size() - s), 64'(8));
    for (int i = 0; i < 4; i++) check("ovl_bubble_cycle", 64'(log_c[s+1+i]), 64'(h + 1 + 2 * i));
    check("ovl_accept_after_tail", 64'(acc2), 64'(log_c[s+4] + 1));
    check("ovl_head2_cycle", 64'(log_c[s+5]), 64'(acc2 + 1));
    check("ovl_head2", 64'(log_f[s+5]), 64'(34'h00000008A));

    // Length above MAX_BEATS is clamped; two beats left for the source
    s = log_f.size();
    send_req(0, 0, 0, 258, 0, 32'h1000, 0, acc);
    wait_idle("clamp");
    check("clamp_count", 64'(log_f.size() - s), 64'(257));
    check("clamp_tail", 64'(log_f[s+256]), 64'(34'h2000010FF));
    check("clamp_tail_cycle", 64'(log_c[s+256]), 64'(acc + 257));
    check("clamp_excess_left", 64'(src_q.size()), 64'(2));
    src_q.delete();
    gap_q.delete();

    // Reset after the 2nd of 4 beats
    s = log_f.size();
    send_req(3, 3, 3, 4, 0, 32'hF0, 0, acc);
    wait_log(s + 3);
    #2 rst_dla = 1'b1;
    #1;
    check("mid_rst_req_rdy", 64'(bus.req_rdy), 64'(1));
    check("mid_rst_dat_rdy", 64'(bus.dat_rdy), 64'(0));
    check("mid_rst_wen", 64'(bus.noc_wrbuf_wen), 64'(0));
    check("mid_rst_wdata", 64'(bus.noc_wrbuf_wdata), 64'(0));
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_flit_cnt", 64'(bus.flit_cnt), 64'(0));
    exp_q.delete();
    src_q.delete();
    gap_q.delete();
    m_pkts  = 0;
    m_flits = 0;
    @(posedge clk_dla);
    #1;
    @(posedge clk_dla);
    #3 rst_dla = 1'b0;
    s = log_f.size();
    send_req(1, 0, 2, 1, 0, 32'h55, 0, acc);
    wait_idle("post_rst");
    check("post_rst_count", 64'(log_f.size() - s), 64'(2));
    check("post_rst_head", 64'(log_f[s]), 64'(34'h000000042));
    check("post_rst_head_cycle", 64'(log_c[s]), 64'(acc + 1));
    check("post_rst_tail", 64'(log_f[s+1]), 64'(34'h200000055));
    check("post_rst_pkt_cnt", 64'(bus.pkt_cnt), 64'(STATS ? 1 : 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
